// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and helpers for the queue drain arbiter
package arb_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_t;

    // Index width for a port count; never narrower than one bit.
    function automatic int src_width(input int num_ports);
        return (num_ports < 2) ? 1 : $clog2(num_ports);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker starting the scan at ptr
module rr_pick
    import arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    localparam int SRC_WIDTH = src_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [SRC_WIDTH-1:0] ptr,
    output logic                 any,
    output logic [SRC_WIDTH-1:0] idx,
    output logic [NUM_PORTS-1:0] onehot
);

    localparam logic [SRC_WIDTH:0] PORTS_W = (SRC_WIDTH+1)'(NUM_PORTS);

    logic [2*NUM_PORTS-1:0] req_dbl;
    logic [NUM_PORTS-1:0]   rot;
    logic [SRC_WIDTH-1:0]   off;
    logic [SRC_WIDTH:0]     sum;

    // Doubling the request vector turns the wrap-around scan into a plain shift.
    assign req_dbl = {req, req};
    assign rot     = NUM_PORTS'(req_dbl >> ptr);

    always_comb begin
        any    = |req;
        off    = '0;
        for (int j = NUM_PORTS - 1; j >= 0; j--) begin
            if (rot[j]) begin
                off = SRC_WIDTH'(j);
            end
        end
        sum    = {1'b0, ptr} + {1'b0, off};
        idx    = (sum >= PORTS_W) ? SRC_WIDTH'(sum - PORTS_W) : sum[SRC_WIDTH-1:0];
        onehot = '0;
        if (any) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// rtl/fifo_rr_arbiter.sv - round-robin drain of per-core queues into one valid/ack holding register
module fifo_rr_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int BIT_WIDTH = 8,
    localparam int SRC_WIDTH = src_width(NUM_PORTS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS-1:0]           q_ready,
    input  logic [NUM_PORTS*BIT_WIDTH-1:0] q_dout,
    output logic [NUM_PORTS-1:0]           q_rd,
    output logic                           out_valid,
    output logic [BIT_WIDTH-1:0]           out_data,
    output logic [SRC_WIDTH-1:0]           out_src,
    input  logic                           out_ack
);

    localparam logic [SRC_WIDTH-1:0] LAST_PORT = SRC_WIDTH'(NUM_PORTS - 1);

    arb_state_t           state;
    arb_state_t           state_next;
    logic [SRC_WIDTH-1:0] rr_ptr;
    logic                 any;
    logic [SRC_WIDTH-1:0] idx;
    logic [NUM_PORTS-1:0] onehot;
    logic                 pop_en;
    logic [BIT_WIDTH-1:0] pop_data;

    rr_pick #(
        .NUM_PORTS(NUM_PORTS)
    ) u_pick (
        .req   (q_ready),
        .ptr   (rr_ptr),
        .any   (any),
        .idx   (idx),
        .onehot(onehot)
    );

    // Gating with rst keeps a pop from being lost inside a reset cycle.
    assign pop_en    = rst & any & ((state == EMPTY) | out_ack);
    assign q_rd      = onehot & {NUM_PORTS{pop_en}};
    assign out_valid = (state == FULL);

    always_comb begin
        pop_data = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (onehot[i]) begin
                pop_data = q_dout[i*BIT_WIDTH +: BIT_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (pop_en) begin
            state_next = FULL;
        end else if ((state == FULL) && out_ack) begin
            state_next = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_data <= '0;
            out_src  <= '0;
            rr_ptr   <= '0;
        end else if (pop_en) begin
            out_data <= pop_data;
            out_src  <= idx;
            rr_ptr   <= (idx == LAST_PORT) ? '0 : idx + 1'b1;
        end
    end

endmodule
